mem_access_stage: RTL

Memory-access (MEM) stage of the five-stage pipeline, directly upstream of the MEM/WB register. Takes the EX/MEM instruction and performs loads and stores against the data RAM over a req/ack handshake, with byte-lane steering and sign/zero extension. While an access is outstanding it stalls the upstream pipeline. It presents `mem_wD`, `mem_rf_we`, `mem_wR`, `mem_pc` and `mem_have_inst` to the MEM/WB register.

---
 rtl/mem_access_stage.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/mem_access_stage.sv
// MEM stage: loads/stores to data RAM over req/ack with lane steering and extension.
// Optional MEM_MISALIGN_EXC_EN: misaligned half/word accesses retire at once with mem_misalign set.
//   state  | meaning
//   S_IDLE | accepting from EX/MEM; non-memory ops forward in one edge
//   S_WAIT | request outstanding on dm_*, waiting for dm_ack
module mem_access_stage #(
    parameter int ADDR_W = 32
) (
    input  logic              ram_clk,
    input  logic              rst_n,
    input  logic              ex_have_inst,
    input  logic [31:0]       ex_alu_c,
    input  logic [31:0]       ex_rD2,
    input  logic              ex_mem_rd,
    input  logic              ex_mem_wr,
    input  logic [1:0]        ex_size,
    input  logic              ex_unsigned,
    input  logic              ex_rf_we,
    input  logic [4:0]        ex_wR,
    input  logic [31:0]       ex_pc,
    output logic              dm_req,
    output logic              dm_we,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [3:0]        dm_be,
    output logic [31:0]       dm_wdata,
    input  logic [31:0]       dm_rdata,
    input  logic              dm_ack,
    output logic              mem_stall,
    output logic [31:0]       mem_wD,
    output logic              mem_rf_we,
    output logic [4:0]        mem_wR,
    output logic [31:0]       mem_pc,
    output logic              mem_have_inst,
    output logic              mem_misalign
);

    typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

    state_t            state, state_nx;
    logic              dm_req_nx, dm_we_nx;
    logic [ADDR_W-1:0] dm_addr_nx;
    logic [3:0]        dm_be_nx;
    logic [31:0]       dm_wdata_nx;
    logic              lat_rd, lat_rd_nx;
    logic [1:0]        lat_size, lat_size_nx;
    logic [1:0]        lat_off, lat_off_nx;
    logic              lat_uns, lat_uns_nx;
    logic              lat_rf_we, lat_rf_we_nx;
    logic [4:0]        lat_wR, lat_wR_nx;
    logic [31:0]       lat_pc, lat_pc_nx;
    logic [31:0]       lat_alu_c, lat_alu_c_nx;
    logic [31:0]       mem_wD_nx;
    logic              mem_rf_we_nx, mem_have_inst_nx, mem_misalign_nx;
    logic [4:0]        mem_wR_nx;
    logic [31:0]       mem_pc_nx;

    logic [1:0]        off, eff_off;
    logic              is_mem, misaligned;
    logic [3:0]        be_steer;
    logic [31:0]       wdata_steer, load_shift, load_ext;
    logic [ADDR_W-1:0] addr_full;

    assign off       = ex_alu_c[1:0];
    assign is_mem    = ex_mem_rd | ex_mem_wr;
    assign addr_full = ADDR_W'(ex_alu_c);

`ifdef MEM_MISALIGN_EXC_EN
    assign misaligned = ((ex_size == 2'b01) && off[0]) || (ex_size[1] && (off != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Offset actually used for lanes: low bits below the access size are dropped.
    always_comb begin
        case (ex_size)
            2'b00: begin
                eff_off     = off;
                be_steer    = 4'b0001 << off;
                wdata_steer = {4{ex_rD2[7:0]}};
            end
            2'b01: begin
                eff_off     = {off[1], 1'b0};
                be_steer    = off[1] ? 4'b1100 : 4'b0011;
                wdata_steer = {2{ex_rD2[15:0]}};
            end
            default: begin
                eff_off     = 2'b00;
                be_steer    = 4'b1111;
                wdata_steer = ex_rD2;
            end
        endcase
    end

    always_comb begin
        load_shift = dm_rdata >> {lat_off, 3'b000};
        case (lat_size)
            2'b00:   load_ext = lat_uns ? {24'd0, load_shift[7:0]}
                                        : {{24{load_shift[7]}}, load_shift[7:0]};
            2'b01:   load_ext = lat_uns ? {16'd0, load_shift[15:0]}
                                        : {{16{load_shift[15]}}, load_shift[15:0]};
            default: load_ext = load_shift;
        endcase
    end

    assign mem_stall = ((state == S_IDLE) && ex_have_inst && is_mem && !misaligned) ||
                       ((state == S_WAIT) && !dm_ack);

    always_comb begin
        state_nx         = state;
        dm_req_nx        = dm_req;
        dm_we_nx         = dm_we;
        dm_addr_nx       = dm_addr;
        dm_be_nx         = dm_be;
        dm_wdata_nx      = dm_wdata;
        lat_rd_nx        = lat_rd;
        lat_size_nx      = lat_size;
        lat_off_nx       = lat_off;
        lat_uns_nx       = lat_uns;
        lat_rf_we_nx     = lat_rf_we;
        lat_wR_nx        = lat_wR;
        lat_pc_nx        = lat_pc;
        lat_alu_c_nx     = lat_alu_c;
        mem_wD_nx        = mem_wD;
        mem_wR_nx        = mem_wR;
        mem_pc_nx        = mem_pc;
        mem_rf_we_nx     = 1'b0;
        mem_have_inst_nx = 1'b0;
        mem_misalign_nx  = 1'b0;
        case (state)
            S_IDLE: begin
                if (ex_have_inst) begin
                    if (!is_mem || misaligned) begin
                        mem_wD_nx        = ex_alu_c;
                        mem_wR_nx        = ex_wR;
                        mem_pc_nx        = ex_pc;
                        mem_have_inst_nx = 1'b1;
                        mem_rf_we_nx     = is_mem ? 1'b0 : ex_rf_we;
                        mem_misalign_nx  = is_mem;
                    end else begin
                        state_nx     = S_WAIT;
                        dm_req_nx    = 1'b1;
                        dm_we_nx     = ex_mem_wr;
                        dm_addr_nx   = {addr_full[ADDR_W-1:2], 2'b00};
                        dm_be_nx     = be_steer;
                        dm_wdata_nx  = wdata_steer;
                        lat_rd_nx    = ex_mem_rd;
                        lat_size_nx  = ex_size;
                        lat_off_nx   = eff_off;
                        lat_uns_nx   = ex_unsigned;
                        lat_rf_we_nx = ex_rf_we;
                        lat_wR_nx    = ex_wR;
                        lat_pc_nx    = ex_pc;
                        lat_alu_c_nx = ex_alu_c;
                    end
                end
            end
            S_WAIT: begin
                if (dm_ack) begin
                    state_nx         = S_IDLE;
                    dm_req_nx        = 1'b0;
                    dm_we_nx         = 1'b0;
                    mem_wD_nx        = lat_rd ? load_ext : lat_alu_c;
                    mem_rf_we_nx     = lat_rf_we;
                    mem_wR_nx        = lat_wR;
                    mem_pc_nx        = lat_pc;
                    mem_have_inst_nx = 1'b1;
                end
            end
            default: state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge ram_clk) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            dm_req        <= 1'b0;
            dm_we         <= 1'b0;
            dm_addr       <= '0;
            dm_be         <= '0;
            dm_wdata      <= '0;
            lat_rd        <= 1'b0;
            lat_size      <= '0;
            lat_off       <= '0;
            lat_uns       <= 1'b0;
            lat_rf_we     <= 1'b0;
            lat_wR        <= '0;
            lat_pc        <= '0;
            lat_alu_c     <= '0;
            mem_wD        <= '0;
            mem_rf_we     <= 1'b0;
            mem_wR        <= '0;
            mem_pc        <= '0;
            mem_have_inst <= 1'b0;
            mem_misalign  <= 1'b0;
        end else begin
            state         <= state_nx;
            dm_req        <= dm_req_nx;
            dm_we         <= dm_we_nx;
            dm_addr       <= dm_addr_nx;
            dm_be         <= dm_be_nx;
            dm_wdata      <= dm_wdata_nx;
            lat_rd        <= lat_rd_nx;
            lat_size      <= lat_size_nx;
            lat_off       <= lat_off_nx;
            lat_uns       <= lat_uns_nx;
            lat_rf_we     <= lat_rf_we_nx;
            lat_wR        <= lat_wR_nx;
            lat_pc        <= lat_pc_nx;
            lat_alu_c     <= lat_alu_c_nx;
            mem_wD        <= mem_wD_nx;
            mem_rf_we     <= mem_rf_we_nx;
            mem_wR        <= mem_wR_nx;
            mem_pc        <= mem_pc_nx;
            mem_have_inst <= mem_have_inst_nx;
            mem_misalign  <= mem_misalign_nx;
        end
    end

endmodule
